// File: rtl/ysyx_22041412_pipe_chain.sv
// rtl/ysyx_22041412_pipe_chain.sv - elastic valid/ready pipeline register chain with hold, flush and counters
module ysyx_22041412_pipe_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic [DEPTH-1:0]       hold,
    input  logic                   flush,
    input  logic [DEPTH-1:0]       flush_mask,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [3:0]             occupancy,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [15:0]            flush_cnt
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] acc;
    logic             in_fire;
    logic [3:0]       kill_cnt;
    logic [16:0]      flush_sum;

    assign kill      = flush_mask & {DEPTH{flush}};
    assign in_ready  = acc[0];
    assign in_fire   = in_valid & acc[0];
    assign out_valid = valid_q[DEPTH-1] & ~hold[DEPTH-1] & ~kill[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign flush_sum = {1'b0, flush_cnt} + {13'b0, kill_cnt};

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage_data
        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    // Ready ripples from the output stage back to the entry; a killed slot counts as free
    always_comb begin
        logic down_acc;
        adv      = '0;
        acc      = '0;
        down_acc = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]   = valid_q[k] & ~hold[k] & ~kill[k] & down_acc;
            acc[k]   = ~hold[k] & (~valid_q[k] | adv[k] | kill[k]);
            down_acc = acc[k];
        end
    end

    // Occupancy and the number of entries dropped by this cycle's flush
    always_comb begin
        occupancy = '0;
        kill_cnt  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + {3'b000, valid_q[k]};
            kill_cnt  = kill_cnt + {3'b000, valid_q[k] & kill[k]};
        end
        if (in_fire & kill[0]) begin
            kill_cnt = kill_cnt + 4'd1;
        end
    end

    // Stage valid bits and payloads; data registers move only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (in_fire) begin
                valid_q[0] <= ~kill[0];
                data_q[0]  <= in_data;
            end else if (kill[0] | adv[0]) begin
                valid_q[0] <= 1'b0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= data_q[k-1];
                end else if (adv[k] | kill[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating performance counters for output bubbles and flushed entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_ready & ~out_valid & ~(&bubble_cnt)) begin
                bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_pipe_chain.sv
// tb/tb_ysyx_22041412_pipe_chain.sv - scoreboard bench for the elastic pipeline chain
module tb_ysyx_22041412_pipe_chain;
    localparam int W = 16;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [D-1:0]   hold = '0;
    logic           flush = 1'b0;
    logic [D-1:0]   flush_mask = '0;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
    logic [3:0]     occupancy;
    logic [31:0]    bubble_cnt;
    logic [15:0]    flush_cnt;

    logic           s_in_ready, s_out_valid;
    logic [7:0]     s_out_data;
    logic [3:0]     s_stage_valid, s_occupancy, s_bubble_cnt;
    logic [31:0]    s_stage_data;
    logic [15:0]    s_flush_cnt;

    int             checks = 0;
    int             errors = 0;
    int             m_stage[$];
    logic [W-1:0]   exp_q[$];
    logic [31:0]    m_bub = '0;
    logic [15:0]    m_fcnt = '0;
    logic [W-1:0]   mon_e;
    int             lat;

    always #5 clk = ~clk;

    ysyx_22041412_pipe_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .hold(hold),
        .flush(flush), .flush_mask(flush_mask), .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    ysyx_22041412_pipe_chain #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_ready(s_in_ready), .in_data(8'h00),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .hold(4'b0000),
        .flush(1'b0), .flush_mask(4'b0000), .stage_valid(s_stage_valid), .stage_data(s_stage_data),
        .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake must match the oldest surviving entry
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard actual=%0h expected=none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard actual=%0h expected=%0h", out_data, mon_e);
                end
            end
        end
    end

    // One cycle: drive inputs, compare against the entry-list model, then advance the model
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic [D-1:0] h, input logic fl, input logic [D-1:0] fm);
        int           occ [D];
        logic [D-1:0] kl, mv, ce, sv;
        logic         room, exp_ov, exp_ir;
        int           s;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy; hold = h; flush = fl; flush_mask = fm;
        #1;
        sv = '0;
        foreach (m_stage[i]) begin
            sv[m_stage[i]] = 1'b1;
            chk("stage_data", 64'(stage_data[m_stage[i]*W +: W]), 64'(exp_q[i]));
        end
        chk("stage_valid", 64'(stage_valid), 64'(sv));
        chk("occupancy", 64'(occupancy), 64'(m_stage.size()));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
        for (int k = 0; k < D; k++) occ[k] = -1;
        foreach (m_stage[i]) occ[m_stage[i]] = i;
        kl = '0; mv = '0; ce = '0;
        room = ordy;
        for (int k = D - 1; k >= 0; k--) begin
            if (occ[k] >= 0) begin
                kl[k] = fl & fm[k];
                mv[k] = !kl[k] && !h[k] && room;
            end
            ce[k] = !h[k] && (occ[k] < 0 || kl[k] || mv[k]);
            room = ce[k];
        end
        exp_ir = ce[0];
        exp_ov = (occ[D-1] >= 0) && !kl[D-1] && !h[D-1];
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) chk("out_data", 64'(out_data), 64'(exp_q[0]));
        for (int i = m_stage.size() - 1; i >= 0; i--) begin
            s = m_stage[i];
            if (kl[s]) begin
                m_stage.delete(i);
                exp_q.delete(i);
                if (m_fcnt != 16'hFFFF) m_fcnt++;
            end else if (mv[s]) begin
                if (s == D - 1) m_stage.delete(i);
                else m_stage[i] = s + 1;
            end
        end
        if (iv && exp_ir) begin
            if (fl && fm[0]) begin
                if (m_fcnt != 16'hFFFF) m_fcnt++;
            end else begin
                m_stage.push_back(0);
                exp_q.push_back(d);
            end
        end
        if (ordy && !exp_ov && m_bub != 32'hFFFF_FFFF) m_bub++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hold = '0; flush = 1'b0; flush_mask = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        m_stage.delete(); exp_q.delete(); m_bub = '0; m_fcnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Saturation on the CNT_W=4 instance
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, '0, 1'b0, '0);
        chk("sat_bubble_10", 64'(s_bubble_cnt), 64'd10);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, '0, 1'b0, '0);
        chk("sat_bubble_20", 64'(s_bubble_cnt), 64'd15);

        // Streaming 1..8
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(i < 8, W'(i + 1), i > 0, '0, 1'b0, '0);
            if (i == 4) begin
                chk("stream_first_valid", 64'(out_valid), 64'd1);
                chk("stream_first_data", 64'(out_data), 64'd1);
            end
            if (i == 11) chk("stream_last_data", 64'(out_data), 64'd8);
        end
        step(1'b0, '0, 1'b1, '0, 1'b0, '0);
        chk("stream_bubble_cnt", 64'(bubble_cnt), 64'd3);

        // Backpressure
        for (int i = 0; i < 4; i++) step(1'b1, W'(21 + i), 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'(25), 1'b0, '0, 1'b0, '0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_occupancy", 64'(occupancy), 64'd4);
            chk("bp_out_data", 64'(out_data), 64'd21);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, '0, 1'b0, '0);

        // Hold bubble on stage 1
        for (int i = 0; i < 14; i++)
            step(i < 8, W'(31 + i), 1'b1, (i == 3 || i == 4) ? 4'b0010 : 4'b0000, 1'b0, '0);

        // Flush of stages 0 and 1 while a new entry arrives
        for (int i = 0; i < 4; i++) step(1'b1, W'(10 + i), 1'b0, '0, 1'b0, '0);
        step(1'b1, W'(14), 1'b0, '0, 1'b1, 4'b0011);
        step(1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("flush_cnt_3", 64'(flush_cnt), 64'd3);
        chk("flush_occupancy", 64'(occupancy), 64'd2);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, '0, 1'b0, '0);

        // Reset with entries in flight, then latency of a fresh entry
        for (int i = 0; i < 3; i++) step(1'b1, W'(1 + i), 1'b0, '0, 1'b0, '0);
        do_reset();
        step(1'b1, W'(16'h00A5), 1'b1, '0, 1'b0, '0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1, '0, 1'b0, '0);
            if (out_valid && lat == 0) lat = i;
        end
        chk("latency_a5", 64'(lat), 64'(D));

        // Randomized traffic with holds and masked flushes
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? D'($urandom) : '0,
                 $urandom_range(0, 15) == 0, D'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, '0, 1'b0, '0);
        #5;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
